// File: rtl/weighted_step_accum_if.sv
// Handshake and result bundle for weighted_step_accum.
// The master side launches/aborts runs; the slave side reports the accumulators and flags.
interface weighted_step_accum_if #(
    parameter int unsigned W = 11
);
    localparam int unsigned AW = W + 2;

    logic          start;
    logic [W-1:0]  n_in;
    logic [1:0]    mode;
    logic          clear;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [W-1:0]  i;
    logic [W-1:0]  n;
    logic          busy;
    logic          done;
    logic          inv_ok;

    modport master (
        output start, n_in, mode, clear,
        input  a, b, i, n, busy, done, inv_ok
    );

    modport slave (
        input  start, n_in, mode, clear,
        output a, b, i, n, busy, done, inv_ok
    );
endinterface

// File: rtl/weighted_step_accum.sv
// Dual-accumulator step engine: steps i up to a captured bound n, splitting a low/high
// weight pair between a and b each cycle, and flags the invariant a+b == (LO+HI)*i.
module weighted_step_accum #(
    parameter int unsigned W       = 11,
    parameter int unsigned STEP_LO = 1,
    parameter int unsigned STEP_HI = 2,
    parameter int unsigned N_RST   = 200
) (
    input logic               clk,
    input logic               rst_n,
    weighted_step_accum_if.slave bus
);
    localparam int unsigned AW = W + 2;
    localparam int unsigned SW = W + 3;

    localparam logic [AW-1:0] LoA  = AW'(STEP_LO);
    localparam logic [AW-1:0] HiA  = AW'(STEP_HI);
    localparam logic [SW-1:0] LoS  = SW'(STEP_LO);
    localparam logic [SW-1:0] HiS  = SW'(STEP_HI);
    localparam logic [SW-1:0] SumS = SW'(STEP_LO + STEP_HI);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] a_q, a_d, b_q, b_d;
    logic [W-1:0]  i_q, i_d, n_q, n_d;
    logic          inv_ok_q, inv_ok_d;
    logic          heavy_a;
    logic [W:0]    i_inc;

    assign i_inc = {1'b0, i_q} + (W+1)'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        n_d     = n_q;
        heavy_a = 1'b0;
        if (bus.clear) begin
            state_d = StIdle;
            a_d     = '0;
            b_d     = '0;
            i_d     = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        n_d     = bus.n_in;
                        a_d     = '0;
                        b_d     = '0;
                        i_d     = '0;
                        state_d = (bus.n_in == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    // Mode 10 holds everything; mode 11 alternates starting with the A-heavy split.
                    if (bus.mode != 2'b10 && i_q < n_q) begin
                        heavy_a = (bus.mode == 2'b01) || (bus.mode == 2'b11 && !i_q[0]);
                        a_d     = a_q + (heavy_a ? HiA : LoA);
                        b_d     = b_q + (heavy_a ? LoA : HiA);
                        i_d     = i_q + W'(1);
                        if (i_inc == {1'b0, n_q}) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Computed from next-state values so the flag lines up with the registers it describes.
    assign inv_ok_d = (SW'(a_d) + SW'(b_d)) == (SumS * SW'(i_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= '0;
            n_q      <= W'(N_RST);
            inv_ok_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            n_q      <= n_d;
            inv_ok_q <= inv_ok_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == StDone) begin
                assert ((SW'(a_q) + SW'(b_q)) == (SumS * SW'(n_q)));
            end
            assert (SW'(a_q) >= LoS * SW'(i_q) && SW'(a_q) <= HiS * SW'(i_q));
            assert (SW'(b_q) >= LoS * SW'(i_q) && SW'(b_q) <= HiS * SW'(i_q));
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.i      = i_q;
    assign bus.n      = n_q;
    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.inv_ok = inv_ok_q;
endmodule

// File: tb/tb_weighted_step_accum.sv
// Directed bench for weighted_step_accum: default instance plus a W=4, LO=1, HI=3 instance.
module tb_weighted_step_accum;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    weighted_step_accum_if #(.W(11)) bus ();
    weighted_step_accum_if #(.W(4))  bus2 ();

    weighted_step_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    weighted_step_accum #(
        .W       (4),
        .STEP_LO (1),
        .STEP_HI (3),
        .N_RST   (7)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int exp_a5[5];
        int exp_b5[5];
        n_checks = 0;
        n_fail   = 0;
        exp_a5   = '{2, 3, 5, 6, 8};
        exp_b5   = '{1, 3, 4, 6, 7};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.n_in = '0; bus.mode = 2'b00; bus.clear = 1'b0;
        bus2.start = 1'b0; bus2.n_in = '0; bus2.mode = 2'b00; bus2.clear = 1'b0;
        #12;
        check("rst_a", 32'(bus.a), 0);
        check("rst_b", 32'(bus.b), 0);
        check("rst_i", 32'(bus.i), 0);
        check("rst_n", 32'(bus.n), 200);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_inv", 32'(bus.inv_ok), 1);
        #1;
        rst_n = 1'b1;

        // n=200, mode 00 throughout
        bus.start = 1'b1; bus.n_in = 11'd200; bus.mode = 2'b00;
        tick();
        bus.start = 1'b0;
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_i0", 32'(bus.i), 0);
        check("t1_a0", 32'(bus.a), 0);
        for (int k = 1; k <= 200; k++) begin
            tick();
            check("t1_inv", 32'(bus.inv_ok), 1);
            if (k == 199) check("t1_done_early", 32'(bus.done), 0);
        end
        check("t1_done", 32'(bus.done), 1);
        check("t1_busy_end", 32'(bus.busy), 0);
        check("t1_a", 32'(bus.a), 200);
        check("t1_b", 32'(bus.b), 400);
        check("t1_i", 32'(bus.i), 200);
        tick();
        check("t1_done_hold", 32'(bus.done), 1);
        check("t1_a_hold", 32'(bus.a), 200);

        // Back-to-back restart from DONE, n=5, mode 11
        bus.start = 1'b1; bus.n_in = 11'd5; bus.mode = 2'b11;
        tick();
        bus.start = 1'b0;
        check("t2_busy", 32'(bus.busy), 1);
        check("t2_a0", 32'(bus.a), 0);
        check("t2_b0", 32'(bus.b), 0);
        check("t2_i0", 32'(bus.i), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_a", 32'(bus.a), 32'(exp_a5[k]));
            check("t2_b", 32'(bus.b), 32'(exp_b5[k]));
            check("t2_inv", 32'(bus.inv_ok), 1);
        end
        check("t2_done", 32'(bus.done), 1);
        check("t2_i", 32'(bus.i), 5);

        // n=4 with two hold cycles
        bus.start = 1'b1; bus.n_in = 11'd4; bus.mode = 2'b00;
        tick();
        bus.start = 1'b0;
        bus.mode = 2'b00; tick();
        check("t3_a1", 32'(bus.a), 1);
        check("t3_b1", 32'(bus.b), 2);
        bus.mode = 2'b10; tick();
        bus.mode = 2'b10; tick();
        check("t3_i_hold", 32'(bus.i), 1);
        check("t3_a_hold", 32'(bus.a), 1);
        bus.mode = 2'b01; tick();
        bus.mode = 2'b00; tick();
        check("t3_done_early", 32'(bus.done), 0);
        check("t3_i3", 32'(bus.i), 3);
        bus.mode = 2'b01; tick();
        check("t3_done", 32'(bus.done), 1);
        check("t3_a", 32'(bus.a), 6);
        check("t3_b", 32'(bus.b), 6);
        check("t3_inv", 32'(bus.inv_ok), 1);

        // n_in=0 goes straight to DONE
        bus.start = 1'b1; bus.n_in = 11'd0; bus.mode = 2'b00;
        tick();
        bus.start = 1'b0;
        check("t4_done", 32'(bus.done), 1);
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_a", 32'(bus.a), 0);
        check("t4_b", 32'(bus.b), 0);
        check("t4_i", 32'(bus.i), 0);
        check("t4_n", 32'(bus.n), 0);
        tick();
        check("t4_busy2", 32'(bus.busy), 0);
        check("t4_done2", 32'(bus.done), 1);

        // clear beats start mid-RUN
        bus.start = 1'b1; bus.n_in = 11'd10; bus.mode = 2'b00;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("t5_i3", 32'(bus.i), 3);
        bus.clear = 1'b1; bus.start = 1'b1;
        tick();
        bus.clear = 1'b0; bus.start = 1'b0;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_i", 32'(bus.i), 0);
        check("t5_a", 32'(bus.a), 0);
        check("t5_n", 32'(bus.n), 10);
        tick();
        check("t5_idle", 32'(bus.busy), 0);

        // Asynchronous reset mid-RUN
        bus.start = 1'b1; bus.n_in = 11'd10;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("t6_i2", 32'(bus.i), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_a", 32'(bus.a), 0);
        check("t6_b", 32'(bus.b), 0);
        check("t6_i", 32'(bus.i), 0);
        check("t6_n", 32'(bus.n), 200);
        check("t6_busy", 32'(bus.busy), 0);
        #2;
        rst_n = 1'b1;

        // Narrow instance: W=4, LO=1, HI=3, n=15, mode 01
        check("t7_rst_n", 32'(bus2.n), 7);
        bus2.start = 1'b1; bus2.n_in = 4'd15; bus2.mode = 2'b01;
        tick();
        bus2.start = 1'b0;
        check("t7_busy", 32'(bus2.busy), 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("t7_inv", 32'(bus2.inv_ok), 1);
            if (k == 14) check("t7_done_early", 32'(bus2.done), 0);
        end
        check("t7_done", 32'(bus2.done), 1);
        check("t7_a", 32'(bus2.a), 45);
        check("t7_b", 32'(bus2.b), 15);
        check("t7_i", 32'(bus2.i), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
